// File: rtl/age_ordered_rs_pkg.sv
// Shared widths, opcode enum and tag constants for the age-ordered reservation station.
package age_ordered_rs_pkg;

  localparam int DEPTH_DEF   = 16;
  localparam int NUM_CDB_DEF = 2;
  localparam int ROB_W_DEF   = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int OP_W_DEF    = 6;

  // Tag 0 means the operand value is already present.
  localparam logic [ROB_W_DEF-1:0] ZERO_ROB = '0;

  typedef enum logic [OP_W_DEF-1:0] {
    OPENUM_NOP,
    OPENUM_ADD, OPENUM_SUB, OPENUM_AND, OPENUM_OR, OPENUM_XOR,
    OPENUM_SLL, OPENUM_SRL, OPENUM_SRA, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR
  } op_e;

endpackage

// File: rtl/age_ordered_rs_if.sv
// Dispatch insert, CDB broadcast and issue packet bundle of the reservation station.
interface age_ordered_rs_if #(
  parameter int NUM_CDB = age_ordered_rs_pkg::NUM_CDB_DEF,
  parameter int ROB_W   = age_ordered_rs_pkg::ROB_W_DEF,
  parameter int DATA_W  = age_ordered_rs_pkg::DATA_W_DEF,
  parameter int OP_W    = age_ordered_rs_pkg::OP_W_DEF
);
  logic                      ins_valid;
  logic                      ins_ready;
  logic [OP_W-1:0]           ins_op;
  logic [DATA_W-1:0]         ins_v1, ins_v2, ins_pc, ins_imm;
  logic [ROB_W-1:0]          ins_q1, ins_q2, ins_rob;

  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*ROB_W-1:0]  cdb_rob;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;

  logic                      iss_valid;
  logic                      iss_ready;
  logic [OP_W-1:0]           iss_op;
  logic [DATA_W-1:0]         iss_v1, iss_v2, iss_pc, iss_imm;
  logic [ROB_W-1:0]          iss_rob;

  // Dispatch / CDB / ALU side
  modport master (
    output ins_valid, ins_op, ins_v1, ins_v2, ins_pc, ins_imm, ins_q1, ins_q2, ins_rob,
    output cdb_valid, cdb_rob, cdb_data, iss_ready,
    input  ins_ready, iss_valid, iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob
  );

  // Reservation station side
  modport slave (
    input  ins_valid, ins_op, ins_v1, ins_v2, ins_pc, ins_imm, ins_q1, ins_q2, ins_rob,
    input  cdb_valid, cdb_rob, cdb_data, iss_ready,
    output ins_ready, iss_valid, iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob
  );
endinterface

// File: rtl/age_ordered_rs_age_picker.sv
// Age matrix tracking relative entry age; grants the oldest eligible entry.
module rs_age_picker #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] ins_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] grant
);
  // older[i][j] set means entry i is older than entry j; only busy rows/cols matter.
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DEPTH-1:0]            blocked;

  // New entry is older than nobody and every other entry becomes older than it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_oh[i] || free_oh[i]) older[i] <= '0;
        else                         older[i] <= older[i] | ins_oh;
      end
    end
  end

  // An eligible entry wins unless some other eligible entry is older.
  always_comb begin
    blocked = '0;
    grant   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++)
        blocked[i] = blocked[i] | (elig[j] & older[j][i]);
      grant[i] = elig[i] & ~blocked[i];
    end
  end
endmodule

// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: CDB wakeup, insert bypass, oldest-first issue.
module age_ordered_rs
  import age_ordered_rs_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NUM_CDB = NUM_CDB_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic                       flush,
  age_ordered_rs_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int               CW     = $clog2(DEPTH+1);
  localparam logic [ROB_W-1:0] NO_TAG = ROB_W'(ZERO_ROB);
  localparam logic [OP_W-1:0]  NOP    = OP_W'(OPENUM_NOP);

  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0][OP_W-1:0]   e_op;
  logic [DEPTH-1:0][DATA_W-1:0] e_v1, e_v2, e_pc, e_imm;
  logic [DEPTH-1:0][ROB_W-1:0]  e_q1, e_q2, e_rob;

  logic [DEPTH-1:0]             free_vec, ins_oh, free_oh, elig, grant;
  logic                         ins_fire, iss_load, iss_fire;
  logic [DEPTH-1:0]             wk1, wk2;
  logic [DEPTH-1:0][DATA_W-1:0] wd1, wd2;
  logic                         byp1, byp2;
  logic [DATA_W-1:0]            bd1, bd2;

  logic                         p_valid;
  logic [OP_W-1:0]              p_op, s_op;
  logic [DATA_W-1:0]            p_v1, p_v2, p_pc, p_imm, s_v1, s_v2, s_pc, s_imm;
  logic [ROB_W-1:0]             p_rob, s_rob;

  // Returns {hit, data}; the lowest channel wins because it is applied last.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [ROB_W-1:0]          q,
    input logic [NUM_CDB-1:0]        cv,
    input logic [NUM_CDB*ROB_W-1:0]  cr,
    input logic [NUM_CDB*DATA_W-1:0] cd
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (cv[k] && q != NO_TAG && cr[k*ROB_W +: ROB_W] == q)
        r = {1'b1, cd[k*DATA_W +: DATA_W]};
    return r;
  endfunction

  // Free slots exclude anything freed by this cycle's issue (busy is still set).
  assign free_vec      = ~busy;
  assign bus.ins_ready = |free_vec;
  assign ins_fire      = bus.ins_valid & bus.ins_ready & rdy & ~flush;
  assign ins_oh        = ins_fire ? (free_vec & (~free_vec + 1'b1)) : '0;

  // Packet register may load when empty or being consumed this cycle.
  assign iss_load = rdy & ~flush & (~p_valid | bus.iss_ready);
  assign free_oh  = iss_load ? grant : '0;
  assign iss_fire = |free_oh;

  // Wakeup matches per entry plus bypass for the incoming operands.
  always_comb begin
    wk1 = '0; wk2 = '0; wd1 = '0; wd2 = '0; elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {wk1[i], wd1[i]} = cdb_match(e_q1[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
      {wk2[i], wd2[i]} = cdb_match(e_q2[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
      elig[i] = busy[i] & (e_q1[i] == NO_TAG) & (e_q2[i] == NO_TAG);
    end
    {byp1, bd1} = cdb_match(bus.ins_q1, bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
    {byp2, bd2} = cdb_match(bus.ins_q2, bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_picker (
    .clk     (clk),
    .rst_n   (rst_n),
    .ins_oh  (ins_oh),
    .free_oh (free_oh),
    .elig    (elig),
    .grant   (grant)
  );

  // One-hot mux of the granted entry into the next packet.
  always_comb begin
    s_op = '0; s_v1 = '0; s_v2 = '0; s_pc = '0; s_imm = '0; s_rob = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        s_op  = s_op  | e_op[i];
        s_v1  = s_v1  | e_v1[i];
        s_v2  = s_v2  | e_v2[i];
        s_pc  = s_pc  | e_pc[i];
        s_imm = s_imm | e_imm[i];
        s_rob = s_rob | e_rob[i];
      end
    end
  end

  // Entry storage: insert into the lowest free slot, wake operands, free on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0; e_op <= '0; e_v1 <= '0; e_v2 <= '0; e_pc <= '0;
      e_imm <= '0; e_q1 <= '0; e_q2 <= '0; e_rob <= '0;
    end else if (flush) begin
      busy <= '0;
    end else if (rdy) begin
      busy <= (busy & ~free_oh) | ins_oh;
      for (int i = 0; i < DEPTH; i++) begin
        if (ins_oh[i]) begin
          e_op[i]  <= bus.ins_op;
          e_pc[i]  <= bus.ins_pc;
          e_imm[i] <= bus.ins_imm;
          e_rob[i] <= bus.ins_rob;
          e_v1[i]  <= byp1 ? bd1 : bus.ins_v1;
          e_q1[i]  <= byp1 ? NO_TAG : bus.ins_q1;
          e_v2[i]  <= byp2 ? bd2 : bus.ins_v2;
          e_q2[i]  <= byp2 ? NO_TAG : bus.ins_q2;
        end else if (busy[i]) begin
          if (wk1[i]) begin e_v1[i] <= wd1[i]; e_q1[i] <= NO_TAG; end
          if (wk2[i]) begin e_v2[i] <= wd2[i]; e_q2[i] <= NO_TAG; end
        end
      end
    end
  end

  // Registered issue packet; held while the ALU back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0; p_op <= NOP; p_v1 <= '0; p_v2 <= '0;
      p_pc <= '0; p_imm <= '0; p_rob <= '0;
    end else if (flush) begin
      p_valid <= 1'b0;
    end else if (iss_load) begin
      p_valid <= |grant;
      if (|grant) begin
        p_op <= s_op; p_v1 <= s_v1; p_v2 <= s_v2;
        p_pc <= s_pc; p_imm <= s_imm; p_rob <= s_rob;
      end
    end
  end

  // Occupancy tracked incrementally so a same-cycle insert and issue cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      occupancy <= '0;
    else if (flush)  occupancy <= '0;
    else if (rdy)    occupancy <= occupancy + CW'(ins_fire) - CW'(iss_fire);
  end

  assign bus.iss_valid = p_valid;
  assign bus.iss_op    = p_op;
  assign bus.iss_v1    = p_v1;
  assign bus.iss_v2    = p_v2;
  assign bus.iss_pc    = p_pc;
  assign bus.iss_imm   = p_imm;
  assign bus.iss_rob   = p_rob;
endmodule

// File: tb/tb_age_ordered_rs.sv
// Bench for age_ordered_rs: directed scenarios plus random traffic against a sequence-number model.
module tb_age_ordered_rs;
  import age_ordered_rs_pkg::*;

  localparam int DEPTH = 16, NC = 2, RW = 4, DW = 32, OW = 6;

  logic       clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
  logic [4:0] occupancy;

  age_ordered_rs_if #(.NUM_CDB(NC), .ROB_W(RW), .DATA_W(DW), .OP_W(OW)) bus ();

  age_ordered_rs #(.DEPTH(DEPTH), .NUM_CDB(NC), .ROB_W(RW), .DATA_W(DW), .OP_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            busy;
    logic [OW-1:0] op;
    logic [DW-1:0] v1, v2, pc, imm;
    logic [RW-1:0] q1, q2, rob;
    int unsigned   seq;
  } ent_t;

  ent_t        m [DEPTH];
  ent_t        m_pkt;
  bit          m_pv;
  int unsigned seq_ctr;
  int          n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
    m_pv = 0;
  endtask

  // First channel (lowest index) carrying the tag supplies the value.
  task automatic cdb_look(input logic [RW-1:0] q, output bit hit, output logic [DW-1:0] d);
    hit = 0; d = '0;
    for (int k = 0; k < NC; k++)
      if (!hit && q != 0 && bus.cdb_valid[k] && bus.cdb_rob[k*RW +: RW] == q) begin
        hit = 1; d = bus.cdb_data[k*DW +: DW];
      end
  endtask

  // Next-state of the model from the current inputs, evaluated before the clock edge.
  task automatic model_step();
    int pick, slot;
    bit h;
    logic [DW-1:0] d;
    ent_t nw;
    if (flush) begin model_reset(); return; end
    if (!rdy) return;
    pick = -1; slot = -1;
    for (int i = DEPTH-1; i >= 0; i--) if (!m[i].busy) slot = i;
    if (!m_pv || bus.iss_ready) begin
      for (int i = 0; i < DEPTH; i++)
        if (m[i].busy && m[i].q1 == 0 && m[i].q2 == 0 && (pick < 0 || m[i].seq < m[pick].seq))
          pick = i;
      m_pv = (pick >= 0);
      if (pick >= 0) begin m_pkt = m[pick]; m[pick].busy = 0; end
    end
    for (int i = 0; i < DEPTH; i++) if (m[i].busy) begin
      cdb_look(m[i].q1, h, d); if (h) begin m[i].v1 = d; m[i].q1 = 0; end
      cdb_look(m[i].q2, h, d); if (h) begin m[i].v2 = d; m[i].q2 = 0; end
    end
    if (bus.ins_valid && slot >= 0) begin
      nw.busy = 1; nw.op = bus.ins_op; nw.pc = bus.ins_pc; nw.imm = bus.ins_imm; nw.rob = bus.ins_rob;
      nw.v1 = bus.ins_v1; nw.q1 = bus.ins_q1; nw.v2 = bus.ins_v2; nw.q2 = bus.ins_q2;
      cdb_look(nw.q1, h, d); if (h) begin nw.v1 = d; nw.q1 = 0; end
      cdb_look(nw.q2, h, d); if (h) begin nw.v2 = d; nw.q2 = 0; end
      nw.seq = seq_ctr++;
      m[slot] = nw;
    end
  endtask

  task automatic check_all();
    chk("ins_ready", bus.ins_ready, m_cnt() < DEPTH);
    chk("occupancy", occupancy, m_cnt());
    chk("iss_valid", bus.iss_valid, m_pv);
    if (m_pv) begin
      chk("iss_op",  bus.iss_op,  m_pkt.op);
      chk("iss_v1",  bus.iss_v1,  m_pkt.v1);
      chk("iss_v2",  bus.iss_v2,  m_pkt.v2);
      chk("iss_pc",  bus.iss_pc,  m_pkt.pc);
      chk("iss_imm", bus.iss_imm, m_pkt.imm);
      chk("iss_rob", bus.iss_rob, m_pkt.rob);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_ins(input logic [RW-1:0] rob, input logic [RW-1:0] q1, input logic [RW-1:0] q2);
    bus.ins_valid = 1; bus.ins_op = OW'($urandom_range(1, 18));
    bus.ins_v1 = $urandom; bus.ins_v2 = $urandom; bus.ins_pc = $urandom; bus.ins_imm = $urandom;
    bus.ins_rob = rob; bus.ins_q1 = q1; bus.ins_q2 = q2;
  endtask

  task automatic set_cdb(input logic [NC-1:0] v, input logic [RW-1:0] r0, input logic [DW-1:0] d0,
                         input logic [RW-1:0] r1, input logic [DW-1:0] d1);
    bus.cdb_valid = v; bus.cdb_rob = {r1, r0}; bus.cdb_data = {d1, d0};
  endtask

  task automatic idle();
    bus.ins_valid = 0; bus.cdb_valid = '0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; seq_ctr = 0;
    idle(); set_ins(0, 0, 0); bus.ins_valid = 0; bus.cdb_rob = '0; bus.cdb_data = '0; bus.iss_ready = 0;
    model_reset();
    #2;
    chk("rst_iss_valid", bus.iss_valid, 0);
    chk("rst_iss_op",    bus.iss_op, OPENUM_NOP);
    chk("rst_occ",       occupancy, 0);
    chk("rst_ins_ready", bus.ins_ready, 1);
    #20 rst_n = 1;
    @(posedge clk); #1;

    // Age order beats index order: B lands in index 0 after A took index 1.
    set_ins(7, 0, 0); cyc();
    set_ins(1, 0, 0); cyc();
    set_ins(2, 0, 0); cyc();
    idle(); bus.iss_ready = 1; cyc();
    chk("order_a", bus.iss_rob, 1);
    cyc(); chk("order_b", bus.iss_rob, 2);
    cyc(); chk("order_drain", bus.iss_valid, 0);

    // Insert-time bypass from channel 1.
    set_ins(4, 3, 0); set_cdb(2'b10, 0, 0, 3, 32'h55); cyc();
    idle(); cyc();
    chk("byp_valid", bus.iss_valid, 1);
    chk("byp_v1", bus.iss_v1, 32'h55);
    cyc();

    // Back-pressure holds packet and entries.
    bus.iss_ready = 0;
    for (int i = 1; i <= 4; i++) begin set_ins(RW'(i), 0, 0); cyc(); end
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("hold_rob", bus.iss_rob, 1); chk("hold_occ", occupancy, 3);
    end
    bus.iss_ready = 1;
    for (int i = 2; i <= 4; i++) begin cyc(); chk("rel_rob", bus.iss_rob, i); end
    cyc();

    // Fill to capacity, then drain one, then insert+issue together, then flush.
    bus.iss_ready = 0;
    for (int i = 0; i < 17; i++) begin set_ins(RW'(i % 15 + 1), 0, 0); cyc(); end
    chk("full_occ", occupancy, 16);
    chk("full_ready", bus.ins_ready, 0);
    idle(); bus.iss_ready = 1; cyc();
    chk("one_out_ready", bus.ins_ready, 1);
    chk("one_out_occ", occupancy, 15);
    set_ins(9, 0, 0); cyc();
    chk("ins_iss_occ", occupancy, 15);
    bus.iss_ready = 0; set_ins(10, 0, 0); cyc();
    idle(); flush = 1; cyc(); flush = 0;
    chk("flush_occ", occupancy, 0);
    chk("flush_valid", bus.iss_valid, 0);
    chk("flush_ready", bus.ins_ready, 1);

    // Two channels wake both operands of one entry in the same cycle.
    bus.iss_ready = 1;
    set_ins(6, 2, 5); cyc();
    idle(); set_cdb(2'b11, 2, 32'hA0A0, 5, 32'hB0B0); cyc();
    chk("dual_not_yet", bus.iss_valid, 0);
    idle(); cyc();
    chk("dual_v1", bus.iss_v1, 32'hA0A0);
    chk("dual_v2", bus.iss_v2, 32'hB0B0);
    cyc();

    // Asynchronous reset while a packet is pending.
    bus.iss_ready = 0;
    set_ins(11, 0, 0); cyc();
    set_ins(12, 0, 0); cyc();
    idle();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", bus.iss_valid, 0);
    chk("arst_op",    bus.iss_op, OPENUM_NOP);
    chk("arst_rob",   bus.iss_rob, 0);
    chk("arst_v1",    bus.iss_v1, 0);
    chk("arst_occ",   occupancy, 0);
    chk("arst_ready", bus.ins_ready, 1);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_all();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bus.ins_valid = ($urandom_range(0, 3) != 0);
      bus.ins_op  = OW'($urandom_range(1, 18));
      bus.ins_v1  = $urandom; bus.ins_v2 = $urandom; bus.ins_pc = $urandom; bus.ins_imm = $urandom;
      bus.ins_rob = RW'($urandom_range(1, 15));
      bus.ins_q1  = ($urandom_range(0, 2) == 0) ? RW'($urandom_range(1, 15)) : '0;
      bus.ins_q2  = ($urandom_range(0, 2) == 0) ? RW'($urandom_range(1, 15)) : '0;
      set_cdb(NC'($urandom_range(0, 3)), RW'($urandom_range(0, 15)), $urandom,
              RW'($urandom_range(0, 15)), $urandom);
      bus.iss_ready = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      cyc();
    end
    rdy = 1; flush = 0; idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/age_ordered_rs.md
AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH, 16, number of entries (power of 2, 4..32)
- NUM_CDB, 2, number of broadcast (CDB) channels
- ROB_W, 4, ROB id width; id 0 means "operand ready"
- DATA_W, 32, operand/pc/imm width
- OP_W, 6, opcode enum width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  mispredict flush from ROB commit
- ins_valid  in  1  dispatch insert request
- ins_ready  out  1  not full; insert is accepted when ins_valid && ins_ready
- ins_op  in  OP_W  opcode
- ins_v1, ins_v2, ins_pc, ins_imm  in  DATA_W each  operands, pc, immediate
- ins_q1, ins_q2  in  ROB_W each  source tags
- ins_rob  in  ROB_W  destination ROB id
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_rob  in  NUM_CDB*ROB_W  per-channel tag, channel k at bits [k*ROB_W +: ROB_W]
- cdb_data  in  NUM_CDB*DATA_W  per-channel result
- iss_valid  out  1  issue packet valid
- iss_ready  in  1  ALU accepts the packet
- iss_op, iss_v1, iss_v2, iss_pc, iss_imm, iss_rob  out  issue packet
- occupancy  out  $clog2(DEPTH+1)  number of busy entries

Function
REQ-003 Each entry SHALL hold busy, op, v1, v2, q1, q2, pc, imm, rob, and an age relation to every other entry.
REQ-004 ins_ready SHALL be 1 when at least one entry is free. It SHALL NOT count an entry freed by issue in the same cycle.
REQ-005 An accepted insert SHALL go to the lowest-index free entry and SHALL be marked younger than every busy entry.
REQ-006 Insert-time bypass: if ins_qX equals a valid cdb_rob[k] and is nonzero, the entry SHALL store vX = cdb_data[k] and qX = 0. The lowest k wins on duplicate tags.
REQ-007 Wakeup: for every busy entry with nonzero qX matching a valid cdb_rob[k], vX SHALL be set to cdb_data[k] and qX to 0 at the next edge. All channels apply in parallel. The lowest k wins on duplicates.
REQ-008 An entry SHALL be eligible when busy, q1 == 0 and q2 == 0, using registered state. An operand woken in cycle N is therefore eligible in cycle N+1.
REQ-009 Issue SHALL select the oldest eligible entry, not the lowest index.
REQ-010 Output handshake: the issue packet SHALL be registered.
- When iss_valid is 0, or iss_valid && iss_ready, the block loads the oldest eligible entry (if any) into the packet, frees that entry, and sets iss_valid to 1; with no eligible entry iss_valid goes to 0.
- When iss_valid && !iss_ready, the packet and all entries' eligibility for issue hold (no overwrite, no loss).
REQ-011 Insert, wakeup and issue SHALL all occur in the same cycle without conflict. A just-freed entry is not reused until the next cycle.
REQ-012 flush SHALL clear all busy bits and iss_valid at the next edge. flush overrides a simultaneous insert or issue. ins_ready is 1 the following cycle.
REQ-013 When rdy is 0 and flush is 0, no state SHALL change and handshakes SHALL NOT complete.
REQ-014 occupancy SHALL equal the popcount of busy bits, registered, and SHALL be exact under a simultaneous insert and issue.

Reset
REQ-015 When rst_n is low, the block SHALL asynchronously clear all busy bits, iss_valid, occupancy and the age state, and set ins_ready to 1.
REQ-016 During reset, iss_op SHALL be NOP, all iss_* data fields 0, and iss_rob 0.
REQ-017 Reset asserted mid-operation SHALL discard all entries and the pending packet, with no partial issue.

Structure
REQ-018 The shared defines file SHALL provide OPENUM_NOP, the opcode enum, ZERO_ROB and the default widths. Nothing opcode-specific SHALL be local to this block.
REQ-019 The age relation and oldest-eligible selection SHALL live in one sub-module, rs_age_picker, parametrised by DEPTH.
- Inputs: insert one-hot, free one-hot, eligible vector.
- Output: one-hot oldest grant.
- Implementation: DEPTH x DEPTH age matrix.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Insert A (q=0, rob 1) then B (q=0, rob 2), iss_ready=1 -> A issues first, then B, even when B sits in a lower index after reuse.
- Insert entry q1=3 with cdb_valid[1]=1, cdb_rob=3, data 0x55 in the same cycle -> v1=0x55, issue in the next cycle.
- Hold iss_ready=0 for 4 cycles with 3 ready entries -> the packet is stable and occupancy stays 3; release -> entries issue in age order, one per cycle.
- Fill 16 entries -> ins_ready=0 and occupancy=16; one issue -> ins_ready=1 next cycle; insert and issue in the same cycle -> occupancy unchanged.
- Both CDB channels wake different tags (2 and 5) of the same entry in one cycle -> both operands are captured, eligible the next cycle.
- flush while full with iss_valid=1 -> occupancy 0, iss_valid 0, next cycle; rst_n pulse mid-issue -> iss_op NOP asynchronously.
